// File: rtl/pe_tile_pkg.sv
// Shared constants for the parametrised PE tile: config register codes, SB select
// encodings and PE opcodes.
package pe_tile_pkg;

  localparam logic [15:0] CFG_PE      = 16'd4;
  localparam logic [15:0] CFG_CB1     = 16'd5;
  localparam logic [15:0] CFG_CB0     = 16'd6;
  localparam logic [15:0] CFG_SB_BASE = 16'd8;

  localparam logic [2:0] SB_OFF = 3'd0;
  localparam logic [2:0] SB_S1  = 3'd1;
  localparam logic [2:0] SB_S2  = 3'd2;
  localparam logic [2:0] SB_S3  = 3'd3;
  localparam logic [2:0] SB_PE  = 3'd4;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_PASS0 = 3'd5,
    OP_ACC   = 3'd6,
    OP_PASS1 = 3'd7
  } pe_op_e;

  // Codes 8..11 address the four switch-box side registers.
  function automatic logic is_sb_code(input logic [15:0] code);
    return code[15:2] == 14'd2;
  endfunction

endpackage

// File: rtl/cb_mux_param.sv
// Connect box: selects one track from a side's inputs or outputs, holding its own
// select register.
module cb_mux_param #(
  parameter int unsigned TRACKS   = 4,
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CB_SEL_W = $clog2(2 * TRACKS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_we,
  input  logic [CB_SEL_W-1:0]       i_wdata,
  input  logic [TRACKS*WIDTH-1:0]   i_in_side,
  input  logic [TRACKS*WIDTH-1:0]   i_out_side,
  output logic [CB_SEL_W-1:0]       o_sel,
  output logic [WIDTH-1:0]          o_data
);

  logic [CB_SEL_W-1:0] r_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel <= '0;
    end else if (i_we) begin
      r_sel <= i_wdata;
    end
  end

  // Selects at or beyond 2*TRACKS match no entry and leave the output at zero.
  always_comb begin
    o_data = '0;
    for (int t = 0; t < int'(TRACKS); t++) begin
      if (r_sel == CB_SEL_W'(t)) begin
        o_data = i_in_side[t*WIDTH +: WIDTH];
      end
      if (r_sel == CB_SEL_W'(t + int'(TRACKS))) begin
        o_data = i_out_side[t*WIDTH +: WIDTH];
      end
    end
  end

  assign o_sel = r_sel;

endmodule

// File: rtl/pe_tile_param.sv
// Parametrised PE tile: four-sided switch box, two connect boxes and a registered PE
// with readable config. Define PE_TILE_OUT_REG_EN to register every out_wire bit.
module pe_tile_param
  import pe_tile_pkg::*;
#(
  parameter int unsigned TRACKS   = 4,
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CB_SEL_W = $clog2(2 * TRACKS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 config_addr,
  input  logic [31:0]                 config_data,
  input  logic                        config_we,
  input  logic                        config_rd,
  input  logic [15:0]                 tile_id,
  input  logic [4*TRACKS*WIDTH-1:0]   in_wire,
  output logic [4*TRACKS*WIDTH-1:0]   out_wire,
  output logic [31:0]                 config_rdata,
  output logic                        config_rvalid
);

  localparam int unsigned SIDE_W = TRACKS * WIDTH;

  logic [15:0]           w_code;
  logic                  w_hit;
  logic                  w_code_valid;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_wr_pe;
  logic [31:0]           w_rd_reg;
  logic [4*SIDE_W-1:0]   w_sb_out;
  logic [WIDTH-1:0]      w_op0;
  logic [WIDTH-1:0]      w_op1;
  logic [WIDTH-1:0]      w_pe_d;
  logic [CB_SEL_W-1:0]   w_cb0_sel;
  logic [CB_SEL_W-1:0]   w_cb1_sel;
  logic                  w_unused_data;

  logic [3*TRACKS-1:0]   r_sb [4];
  pe_op_e                r_pe_op;
  logic [WIDTH-1:0]      r_pe_out;
  logic                  r_rvalid;
  logic [31:0]           r_rdata;

  assign w_code        = config_addr[31:16];
  assign w_hit         = config_addr[15:0] == tile_id;
  assign w_code_valid  = (w_code == CFG_PE) || (w_code == CFG_CB1) || (w_code == CFG_CB0) ||
                         is_sb_code(w_code);
  assign w_wr          = config_we && w_hit;
  assign w_rd          = config_rd && w_hit && w_code_valid;
  assign w_wr_pe       = w_wr && (w_code == CFG_PE);
  assign w_unused_data = ^config_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 4; s++) begin
        r_sb[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (w_wr && (w_code == CFG_SB_BASE + 16'(s))) begin
          r_sb[s] <= config_data[3*TRACKS-1:0];
        end
      end
    end
  end

  always_comb begin
    w_sb_out = '0;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < int'(TRACKS); t++) begin
        case (r_sb[s][3*t +: 3])
          SB_S1: w_sb_out[(s*TRACKS + t)*WIDTH +: WIDTH] =
                   in_wire[(((s + 1) % 4)*TRACKS + t)*WIDTH +: WIDTH];
          SB_S2: w_sb_out[(s*TRACKS + t)*WIDTH +: WIDTH] =
                   in_wire[(((s + 2) % 4)*TRACKS + t)*WIDTH +: WIDTH];
          SB_S3: w_sb_out[(s*TRACKS + t)*WIDTH +: WIDTH] =
                   in_wire[(((s + 3) % 4)*TRACKS + t)*WIDTH +: WIDTH];
          SB_PE: w_sb_out[(s*TRACKS + t)*WIDTH +: WIDTH] = r_pe_out;
          default: w_sb_out[(s*TRACKS + t)*WIDTH +: WIDTH] = '0;
        endcase
      end
    end
  end

`ifdef PE_TILE_OUT_REG_EN
  logic [4*SIDE_W-1:0] r_out_wire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_wire <= '0;
    end else begin
      r_out_wire <= w_sb_out;
    end
  end

  assign out_wire = r_out_wire;
`else
  assign out_wire = w_sb_out;
`endif

  cb_mux_param #(
    .TRACKS   (TRACKS),
    .WIDTH    (WIDTH),
    .CB_SEL_W (CB_SEL_W)
  ) u_cb0 (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_we       (w_wr && (w_code == CFG_CB0)),
    .i_wdata    (config_data[CB_SEL_W-1:0]),
    .i_in_side  (in_wire[0 +: SIDE_W]),
    .i_out_side (out_wire[0 +: SIDE_W]),
    .o_sel      (w_cb0_sel),
    .o_data     (w_op0)
  );

  cb_mux_param #(
    .TRACKS   (TRACKS),
    .WIDTH    (WIDTH),
    .CB_SEL_W (CB_SEL_W)
  ) u_cb1 (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_we       (w_wr && (w_code == CFG_CB1)),
    .i_wdata    (config_data[CB_SEL_W-1:0]),
    .i_in_side  (in_wire[SIDE_W +: SIDE_W]),
    .i_out_side (out_wire[SIDE_W +: SIDE_W]),
    .o_sel      (w_cb1_sel),
    .o_data     (w_op1)
  );

  always_comb begin
    w_pe_d = '0;
    unique case (r_pe_op)
      OP_ADD:   w_pe_d = w_op0 + w_op1;
      OP_SUB:   w_pe_d = w_op0 - w_op1;
      OP_AND:   w_pe_d = w_op0 & w_op1;
      OP_OR:    w_pe_d = w_op0 | w_op1;
      OP_XOR:   w_pe_d = w_op0 ^ w_op1;
      OP_PASS0: w_pe_d = w_op0;
      OP_ACC:   w_pe_d = r_pe_out + w_op0;
      OP_PASS1: w_pe_d = w_op1;
    endcase
  end

  // A PE config write restarts the accumulator alongside the opcode change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pe_op  <= OP_ADD;
      r_pe_out <= '0;
    end else if (w_wr_pe) begin
      r_pe_op  <= pe_op_e'(config_data[2:0]);
      r_pe_out <= '0;
    end else begin
      r_pe_out <= w_pe_d;
    end
  end

  always_comb begin
    w_rd_reg = '0;
    if (w_code == CFG_PE) begin
      w_rd_reg = 32'(r_pe_op);
    end else if (w_code == CFG_CB0) begin
      w_rd_reg = 32'(w_cb0_sel);
    end else if (w_code == CFG_CB1) begin
      w_rd_reg = 32'(w_cb1_sel);
    end else if (is_sb_code(w_code)) begin
      w_rd_reg = 32'(r_sb[w_code[1:0]]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd;
      r_rdata  <= w_rd ? w_rd_reg : 32'd0;
    end
  end

  assign config_rvalid = r_rvalid;
  assign config_rdata  = r_rdata;

endmodule

// File: tb/tb_pe_tile_param.sv
// Directed bench for pe_tile_param: tile A (4 tracks x 4 bits) and tile B (3 tracks x 4 bits)
// share the clock, reset and config bus with distinct tile ids.
module tb_pe_tile_param;

  localparam logic [15:0] ID_A = 16'h0012;
  localparam logic [15:0] ID_B = 16'h0034;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_we;
  logic        cfg_rd;
  logic [63:0] in_a;
  logic [63:0] out_a;
  logic [31:0] rdata_a;
  logic        rvalid_a;
  logic [47:0] in_b;
  logic [47:0] out_b;
  logic [31:0] rdata_b;
  logic        rvalid_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_tile_param #(
    .TRACKS (4),
    .WIDTH  (4)
  ) u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .config_addr   (cfg_addr),
    .config_data   (cfg_data),
    .config_we     (cfg_we),
    .config_rd     (cfg_rd),
    .tile_id       (ID_A),
    .in_wire       (in_a),
    .out_wire      (out_a),
    .config_rdata  (rdata_a),
    .config_rvalid (rvalid_a)
  );

  pe_tile_param #(
    .TRACKS (3),
    .WIDTH  (4)
  ) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .config_addr   (cfg_addr),
    .config_data   (cfg_data),
    .config_we     (cfg_we),
    .config_rd     (cfg_rd),
    .tile_id       (ID_B),
    .in_wire       (in_b),
    .out_wire      (out_b),
    .config_rdata  (rdata_b),
    .config_rvalid (rvalid_b)
  );

  function automatic logic [3:0] fa(input logic [63:0] v, input int s, input int t);
    return v[(s*4 + t)*4 +: 4];
  endfunction

  function automatic logic [3:0] fb(input logic [47:0] v, input int s, input int t);
    return v[(s*3 + t)*4 +: 4];
  endfunction

  task automatic set_a(input int s, input int t, input logic [3:0] val);
    in_a[(s*4 + t)*4 +: 4] = val;
  endtask

  task automatic set_b(input int s, input int t, input logic [3:0] val);
    in_b[(s*3 + t)*4 +: 4] = val;
  endtask

  task automatic cfg_write(input logic [15:0] id, input logic [15:0] code,
                           input logic [31:0] data);
    @(negedge clk);
    cfg_addr = {code, id};
    cfg_data = data;
    cfg_we   = 1'b1;
    @(negedge clk);
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
  endtask

  // Issues a one-cycle read; returns at the negedge where the response is visible.
  task automatic cfg_read(input logic [15:0] id, input logic [15:0] code);
    @(negedge clk);
    cfg_addr = {code, id};
    cfg_rd   = 1'b1;
    @(negedge clk);
    cfg_rd   = 1'b0;
    cfg_addr = '0;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    cfg_we   = 1'b0;
    cfg_rd   = 1'b0;
    in_a     = '1;
    in_b     = '1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_a !== 64'h0) begin
      n_err++; $display("FAIL reset_out_a got %h want 0", out_a);
    end
    n_vec++;
    if (rvalid_a !== 1'b0 || rdata_a !== 32'h0) begin
      n_err++; $display("FAIL reset_rd_a got %b/%h want 0/0", rvalid_a, rdata_a);
    end
    n_vec++;
    if (out_b !== 48'h0) begin
      n_err++; $display("FAIL reset_out_b got %h want 0", out_b);
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_a !== 64'h0 || rvalid_a !== 1'b0) begin
      n_err++; $display("FAIL release_out_a got %h/%b want 0/0", out_a, rvalid_a);
    end
    in_a = '0;
    in_b = '0;
  endtask

  task automatic test_sb_routing;
    cfg_write(ID_A, 16'd10, 32'h001);
    set_a(3, 0, 4'hA);
    #1;
    n_vec++;
    if (fa(out_a, 2, 0) !== 4'hA) begin
      n_err++; $display("FAIL sb_s2t0_sel1 got %h want a", fa(out_a, 2, 0));
    end
    n_vec++;
    if ((out_a & ~(64'hF << 32)) !== 64'h0) begin
      n_err++; $display("FAIL sb_others_zero got %h want 0", out_a & ~(64'hF << 32));
    end
    cfg_write(ID_A, 16'd10, 32'h002);
    set_a(0, 0, 4'h5);
    #1;
    n_vec++;
    if (fa(out_a, 2, 0) !== 4'h5) begin
      n_err++; $display("FAIL sb_s2t0_sel2 got %h want 5", fa(out_a, 2, 0));
    end
    cfg_write(ID_A, 16'd10, 32'h018);
    set_a(1, 1, 4'h6);
    #1;
    n_vec++;
    if (fa(out_a, 2, 1) !== 4'h6 || fa(out_a, 2, 0) !== 4'h0) begin
      n_err++; $display("FAIL sb_s2t1_sel3 got %h/%h want 6/0", fa(out_a, 2, 1), fa(out_a, 2, 0));
    end
    cfg_write(16'h0099, 16'd10, 32'h028);
    n_vec++;
    if (fa(out_a, 2, 1) !== 4'h6) begin
      n_err++; $display("FAIL sb_wrong_id got %h want 6", fa(out_a, 2, 1));
    end
    cfg_write(ID_A, 16'd10, 32'h028);
    n_vec++;
    if (fa(out_a, 2, 1) !== 4'h0) begin
      n_err++; $display("FAIL sb_sel5_zero got %h want 0", fa(out_a, 2, 1));
    end
    cfg_write(ID_A, 16'd10, 32'h0);
    in_a = '0;
  endtask

  task automatic test_pe_add;
    cfg_write(ID_A, 16'd6, 32'd1);
    cfg_write(ID_A, 16'd5, 32'd2);
    cfg_write(ID_A, 16'd8, 32'h004);
    cfg_write(ID_A, 16'd4, 32'd0);
    set_a(0, 1, 4'd5);
    set_a(1, 2, 4'd7);
    #1;
    n_vec++;
    if (fa(out_a, 0, 0) !== 4'h0) begin
      n_err++; $display("FAIL pe_cleared got %h want 0", fa(out_a, 0, 0));
    end
    @(negedge clk);
    n_vec++;
    if (fa(out_a, 0, 0) !== 4'hC) begin
      n_err++; $display("FAIL pe_add_5_7 got %h want c", fa(out_a, 0, 0));
    end
    set_a(0, 1, 4'd9);
    set_a(1, 2, 4'd9);
    @(negedge clk);
    n_vec++;
    if (fa(out_a, 0, 0) !== 4'h2) begin
      n_err++; $display("FAIL pe_add_wrap got %h want 2", fa(out_a, 0, 0));
    end
    cfg_write(ID_A, 16'd4, 32'd1);
    set_a(0, 1, 4'd3);
    set_a(1, 2, 4'd5);
    @(negedge clk);
    n_vec++;
    if (fa(out_a, 0, 0) !== 4'hE) begin
      n_err++; $display("FAIL pe_sub_3_5 got %h want e", fa(out_a, 0, 0));
    end
  endtask

  task automatic test_acc;
    logic [3:0] exp_v;
    set_a(0, 1, 4'd3);
    cfg_write(ID_A, 16'd4, 32'd6);
    n_vec++;
    if (fa(out_a, 0, 0) !== 4'h0) begin
      n_err++; $display("FAIL acc_start got %h want 0", fa(out_a, 0, 0));
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = 4'(3 * k);
      n_vec++;
      if (fa(out_a, 0, 0) !== exp_v) begin
        n_err++; $display("FAIL acc_step%0d got %h want %h", k, fa(out_a, 0, 0), exp_v);
      end
    end
    cfg_write(ID_A, 16'd4, 32'd6);
    n_vec++;
    if (fa(out_a, 0, 0) !== 4'h0) begin
      n_err++; $display("FAIL acc_rewrite_clear got %h want 0", fa(out_a, 0, 0));
    end
    @(negedge clk);
    n_vec++;
    if (fa(out_a, 0, 0) !== 4'h3) begin
      n_err++; $display("FAIL acc_restart got %h want 3", fa(out_a, 0, 0));
    end
    cfg_write(ID_A, 16'd4, 32'd5);
    set_a(0, 1, 4'd9);
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if (fa(out_a, 0, 0) !== 4'h9) begin
        n_err++; $display("FAIL pass0 got %h want 9", fa(out_a, 0, 0));
      end
    end
  endtask

  task automatic test_readback;
    cfg_write(ID_A, 16'd6, 32'h5);
    cfg_read(ID_A, 16'd6);
    n_vec++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'h5) begin
      n_err++; $display("FAIL rd_cb0 got %b/%h want 1/5", rvalid_a, rdata_a);
    end
    n_vec++;
    if (rvalid_b !== 1'b0) begin
      n_err++; $display("FAIL rd_other_tile got %b want 0", rvalid_b);
    end
    cfg_read(ID_A, 16'd7);
    n_vec++;
    if (rvalid_a !== 1'b0 || rdata_a !== 32'h0) begin
      n_err++; $display("FAIL rd_code7 got %b/%h want 0/0", rvalid_a, rdata_a);
    end
    cfg_read(16'h0099, 16'd6);
    n_vec++;
    if (rvalid_a !== 1'b0 || rdata_a !== 32'h0) begin
      n_err++; $display("FAIL rd_wrong_id got %b/%h want 0/0", rvalid_a, rdata_a);
    end
    cfg_read(ID_A, 16'd8);
    n_vec++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'h4) begin
      n_err++; $display("FAIL rd_sb0 got %b/%h want 1/4", rvalid_a, rdata_a);
    end
    cfg_read(ID_A, 16'd4);
    n_vec++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'h5) begin
      n_err++; $display("FAIL rd_pe got %b/%h want 1/5", rvalid_a, rdata_a);
    end
    @(negedge clk);
    cfg_addr = {16'd6, ID_A};
    cfg_data = 32'h3;
    cfg_we   = 1'b1;
    cfg_rd   = 1'b1;
    @(negedge clk);
    cfg_we   = 1'b0;
    cfg_rd   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    n_vec++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'h5) begin
      n_err++; $display("FAIL rd_during_wr got %b/%h want 1/5", rvalid_a, rdata_a);
    end
    cfg_read(ID_A, 16'd6);
    n_vec++;
    if (rdata_a !== 32'h3) begin
      n_err++; $display("FAIL rd_after_wr got %h want 3", rdata_a);
    end
    cfg_write(ID_A, 16'd6, 32'hFFFF_FFF9);
    cfg_read(ID_A, 16'd6);
    n_vec++;
    if (rdata_a !== 32'h1) begin
      n_err++; $display("FAIL rd_truncated got %h want 1", rdata_a);
    end
  endtask

  task automatic test_cb_range;
    in_b = '1;
    cfg_write(ID_B, 16'd8, 32'h004);
    cfg_write(ID_B, 16'd4, 32'd5);
    cfg_write(ID_B, 16'd6, 32'd7);
    @(negedge clk);
    n_vec++;
    if (fb(out_b, 0, 0) !== 4'h0) begin
      n_err++; $display("FAIL cb_sel7_zero got %h want 0", fb(out_b, 0, 0));
    end
    cfg_write(ID_B, 16'd6, 32'd2);
    @(negedge clk);
    n_vec++;
    if (fb(out_b, 0, 0) !== 4'hF) begin
      n_err++; $display("FAIL cb_sel2_in got %h want f", fb(out_b, 0, 0));
    end
    cfg_write(ID_B, 16'd6, 32'd6);
    @(negedge clk);
    n_vec++;
    if (fb(out_b, 0, 0) !== 4'h0) begin
      n_err++; $display("FAIL cb_sel6_zero got %h want 0", fb(out_b, 0, 0));
    end
    cfg_write(ID_B, 16'd9, 32'h001);
    cfg_write(ID_B, 16'd4, 32'd7);
    cfg_write(ID_B, 16'd5, 32'd3);
    @(negedge clk);
    n_vec++;
    if (fb(out_b, 0, 0) !== 4'hF) begin
      n_err++; $display("FAIL cb1_outwire got %h want f", fb(out_b, 0, 0));
    end
    set_b(2, 0, 4'h6);
    @(negedge clk);
    n_vec++;
    if (fb(out_b, 0, 0) !== 4'h6) begin
      n_err++; $display("FAIL cb1_outwire_upd got %h want 6", fb(out_b, 0, 0));
    end
    cfg_read(ID_B, 16'd9);
    n_vec++;
    if (rvalid_b !== 1'b1 || rdata_b !== 32'h1) begin
      n_err++; $display("FAIL rd_b_sb1 got %b/%h want 1/1", rvalid_b, rdata_b);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cfg_addr = {16'd6, ID_A};
    cfg_rd   = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (rvalid_a !== 1'b1) begin
      n_err++; $display("FAIL mid_rvalid_pre got %b want 1", rvalid_a);
    end
    reset  = 1'b0;
    cfg_rd = 1'b0;
    #1;
    n_vec++;
    if (rvalid_a !== 1'b0 || rdata_a !== 32'h0 || out_a !== 64'h0) begin
      n_err++; $display("FAIL mid_async_clear got %b/%h/%h want 0/0/0", rvalid_a, rdata_a, out_a);
    end
    n_vec++;
    if (out_b !== 48'h0) begin
      n_err++; $display("FAIL mid_out_b got %h want 0", out_b);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rvalid_a !== 1'b0) begin
      n_err++; $display("FAIL mid_post_release got %b want 0", rvalid_a);
    end
    cfg_read(ID_A, 16'd6);
    n_vec++;
    if (rvalid_a !== 1'b1 || rdata_a !== 32'h0) begin
      n_err++; $display("FAIL mid_cb0_reset got %b/%h want 1/0", rvalid_a, rdata_a);
    end
  endtask

  initial begin
    test_reset();
    test_sb_routing();
    test_pe_add();
    test_acc();
    test_readback();
    test_cb_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_tile_param.md
Name: pe_tile_param

Overview:
- Parametrised successor to the fixed 4-track, 1-bit, left-edge PE tile.
- Provides TRACKS tracks per side, WIDTH bits per track, and all four sides driven.
- Has per-side switch-box config words, two connect boxes and a registered multi-op PE with an accumulate mode.
- Config registers are readable back over the config bus. The tile is instantiated in the array in place of the fixed edge/interior variants.

Parameters:
- TRACKS, 4: tracks per side. Legal range 1..10.
- WIDTH, 1: bits per track and PE datapath width. Legal range 1..16.
- CB_SEL_W, $clog2(2*TRACKS): connect-box select width. Derived; must not be overridden.

Ports:
- clk  in  1  tile clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- config_addr  in  32  [15:0] tile id match, [31:16] register code
- config_data  in  32  write data
- config_we  in  1  write strobe
- config_rd  in  1  read strobe
- tile_id  in  16  this tile's id
- in_wire  in  4*TRACKS*WIDTH  index {side,track}; side 0..3, track-major within side
- out_wire  out  4*TRACKS*WIDTH  same packing as in_wire
- config_rdata  out  32  readback data
- config_rvalid  out  1  readback valid

Behaviour:
- Register codes (config_addr[31:16]):
  - 4 = PE
  - 5 = CB1
  - 6 = CB0
  - 8+s = SB side s (s = 0..3)
  - 7 and all others reserved: writes ignored, reads return rvalid 0.
- Write:
  - Condition: config_we=1, addr[15:0]==tile_id and a valid code.
  - The register loads at the next clk rise, taking config_data zero-truncated to the register width.
- SB side register: TRACKS 3-bit fields, field t at bits [3t+2:3t]. out_wire[s][t] is selected as:
  - 0 → zero
  - 1 → in_wire[(s+1)%4][t]
  - 2 → in_wire[(s+2)%4][t]
  - 3 → in_wire[(s+3)%4][t]
  - 4 → pe_out
  - 5..7 → zero
  - The SB path is combinational unless the optional feature is enabled.
- CB0 / CB1 (CB_SEL_W bits, data from sides 0 / 1 respectively):
  - sel < TRACKS → in_wire[side][sel]
  - TRACKS ≤ sel < 2*TRACKS → out_wire[side][sel-TRACKS]
  - Otherwise → zero.
  - Results are op0 / op1.
- PE register: bits [2:0] op. pe_out is a registered WIDTH-bit value, updated every cycle, 1-cycle latency. All arithmetic wraps mod 2^WIDTH.
  - 0 ADD: op0+op1
  - 1 SUB: op0-op1
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 PASS0
  - 6 ACC: pe_out+op0
  - 7 PASS1
- A write to the PE register clears pe_out to 0 on the same edge; the new op takes effect the following cycle.
- pe_out is registered, so no combinational loop exists through CB→PE→SB.
- Read:
  - Condition: config_rd=1 with a matching, valid address.
  - Next cycle: config_rvalid=1 and config_rdata = that register zero-extended.
  - Otherwise rvalid=0 and rdata=0. The read is single-cycle; no backpressure.
- Simultaneous write and read of the same register: the read returns the pre-write value.
- Reset values (asynchronous on reset=0): all config registers 0 (SB outputs zero, CBs select in track 0, PE op ADD), pe_out 0, config_rvalid 0, config_rdata 0.
- A reset asserted mid-operation discards any pending read; no rvalid is produced after release.

Optional Feature:
- Macro PE_TILE_OUT_REG_EN.
- Defined: every out_wire bit is registered, giving a 1-cycle SB latency, with reset value 0. CB selections of out_wire tracks see the registered value.
- Undefined: out_wire is the combinational SB mux output.

Decomposition:
- Shared package/header (pe_tile_pkg) holds:
  - register codes CFG_PE=4, CFG_CB1=5, CFG_CB0=6, CFG_SB_BASE=8
  - SB select encodings SB_OFF/SB_S1/SB_S2/SB_S3/SB_PE
  - PE opcode constants
- One sub-module, cb_mux_param (parametrised TRACKS/WIDTH connect box holding its own config register), instantiated twice.
- The SB and PE are inline.

Test Plan:
- Reset: hold reset=0 with in_wire=all ones → out_wire=0, config_rvalid=0. Release: out_wire stays 0 (SB sel 0).
- SB routing, TRACKS=4, WIDTH=4: write SB side 2 = 0x001 (track0 sel 1), drive in_wire[3][0]=0xA → out_wire[2][0]=0xA combinationally (or one cycle later with PE_TILE_OUT_REG_EN). Other side-2 tracks stay 0.
- PE ADD: CB0 sel 1, CB1 sel 2, in_wire[0][1]=5, in_wire[1][2]=7, SB side0 track0 sel 4 → out_wire[0][0]=0xC one cycle after the inputs settle. With WIDTH=4, inputs 9+9 → 0x2 (wrap).
- ACC mode: write PE=6, op0=3 held → pe_out sequence 0,3,6,9,12,15,2. A PE rewrite mid-sequence → pe_out 0 on that edge.
- Readback: write CB0=0x5, then config_rd same address → next cycle rvalid=1, rdata=0x5. Read of code 7 or a wrong tile_id → rvalid 0, rdata 0. Same-cycle write 0x3 and read → rdata 0x5.
- Out-of-range CB sel: TRACKS=3 (CB_SEL_W=3), CB0=7 → op0=0. PASS0 → pe_out 0.
